imem_port_arbiter: RTL and testbench

//  Shares the single-port synchronous instruction RAM between two requesters:
//  M0 = IF-stage fetch, M1 = data/loader port (self-modifying code, boot loader).

---
 rtl/imem_port_arbiter.sv | 118 +++++++++++
 tb/tb_imem_port_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the single-port synchronous instruction RAM.
// M1 (data/loader) has priority; a starvation counter boosts M0 (fetch) to guarantee progress.
module imem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_cancel,
  output logic              m0_addr_ok,
  output logic              m0_data_ok,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [3:0]        m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_addr_ok,
  output logic              m1_data_ok,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {
    PRIO_M1  = 1'b0,
    BOOST_M0 = 1'b1
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       resp_vld_q, resp_vld_d;
  logic       resp_id_q, resp_id_d;
  logic       resp_drop_q, resp_drop_d;
  logic       gnt_m0, gnt_m1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= PRIO_M1;
      starve_cnt_q <= '0;
      resp_vld_q   <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_drop_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      resp_vld_q   <= resp_vld_d;
      resp_id_q    <= resp_id_d;
      resp_drop_q  <= resp_drop_d;
    end
  end

  // Grant decode; held off while reset is asserted so nothing is accepted during reset.
  always_comb begin
    // NOTE: defaults first so no path through the block leaves a signal unassigned (no latches).
    gnt_m0 = 1'b0;
    gnt_m1 = 1'b0;
    if (reset) begin
      unique case (state_q)
        PRIO_M1: begin
          if (m1_req)      gnt_m1 = 1'b1;
          else if (m0_req) gnt_m0 = 1'b1;
        end
        BOOST_M0: begin
          if (m0_req)      gnt_m0 = 1'b1;
          else if (m1_req) gnt_m1 = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (m0_req && !gnt_m0) begin
      starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 4'd1;
    end
  end

  // Entering BOOST_M0 on the counter's next value lets M0 win the very next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PRIO_M1:  if (starve_cnt_d == STARVE_LIM) state_d = BOOST_M0;
      BOOST_M0: if (gnt_m0 || !m0_req)          state_d = PRIO_M1;
      default:  state_d = PRIO_M1;
    endcase
  end

  always_comb begin
    resp_vld_d  = gnt_m0 | gnt_m1;
    resp_id_d   = gnt_m1;
    resp_drop_d = gnt_m0 & m0_cancel;
  end

  assign m0_addr_ok = gnt_m0;
  assign m1_addr_ok = gnt_m1;

  assign ram_en    = gnt_m0 | gnt_m1;
  assign ram_wen   = gnt_m1 ? m1_wen : 4'b0000;
  assign ram_addr  = gnt_m1 ? m1_addr : m0_addr;
  assign ram_wdata = gnt_m1 ? m1_wdata : '0;

  // A cancel landing on the response cycle itself still kills the fetch.
  assign m0_data_ok = resp_vld_q & ~resp_id_q & ~resp_drop_q & ~m0_cancel;
  assign m1_data_ok = resp_vld_q & resp_id_q;
  assign m0_rdata   = ram_rdata;
  assign m1_rdata   = ram_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: table vectors, directed corner sequences and random traffic
// checked against a denial-count / pending-response reference model with a golden memory.
module tb_imem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam logic [31:0] BASE = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_cancel, m0_addr_ok, m0_data_ok;
  logic [31:0] m0_addr, m0_rdata;
  logic        m1_req, m1_addr_ok, m1_data_ok;
  logic [3:0]  m1_wen;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  imem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_cancel(m0_cancel),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM macro: 64 words, read data registered one cycle after ram_en.
  logic [31:0] mem [64];
  logic [31:0] golden [64];

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr[7:2]];
    end
  end

  function automatic logic [31:0] addr_of(input int idx);
    return BASE + 32'(idx % 64) * 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: M0 wins when it has waited STARVE_MAX cycles or M1 is idle;
  // every grant leaves one pending response that surfaces on the following cycle.
  int          denials = 0;
  logic        pend_vld = 1'b0, pend_m1 = 1'b0, pend_drop = 1'b0, pend_rd = 1'b0;
  logic [31:0] pend_data = '0;
  logic        e_g0, e_g1, e_d0, e_d1;

  always @(negedge clk) begin
    if (!reset) begin
      check("m_rst_aok0", 32'(m0_addr_ok), 0);
      check("m_rst_aok1", 32'(m1_addr_ok), 0);
      check("m_rst_en",   32'(ram_en), 0);
      check("m_rst_wen",  32'(ram_wen), 0);
      check("m_rst_dok0", 32'(m0_data_ok), 0);
      check("m_rst_dok1", 32'(m1_data_ok), 0);
      denials  = 0;
      pend_vld = 1'b0;
    end else begin
      e_g0 = m0_req && (!m1_req || denials >= STARVE_MAX);
      e_g1 = m1_req && !e_g0;
      e_d0 = pend_vld && !pend_m1 && !pend_drop && !m0_cancel;
      e_d1 = pend_vld && pend_m1;
      check("m_aok0", 32'(m0_addr_ok), 32'(e_g0));
      check("m_aok1", 32'(m1_addr_ok), 32'(e_g1));
      check("m_en",   32'(ram_en), 32'(e_g0 || e_g1));
      check("m_wen",  32'(ram_wen), e_g1 ? 32'(m1_wen) : 32'd0);
      if (e_g0 || e_g1) check("m_addr", ram_addr, e_g1 ? m1_addr : m0_addr);
      if (e_g1 && m1_wen != 4'd0) check("m_wdata", ram_wdata, m1_wdata);
      check("m_dok0", 32'(m0_data_ok), 32'(e_d0));
      check("m_dok1", 32'(m1_data_ok), 32'(e_d1));
      if (e_d0) check("m_rdata0", m0_rdata, pend_data);
      if (e_d1 && pend_rd) check("m_rdata1", m1_rdata, pend_data);

      denials   = (m0_req && !e_g0) ? ((denials + 1 > STARVE_MAX) ? STARVE_MAX : denials + 1) : 0;
      pend_vld  = e_g0 || e_g1;
      pend_m1   = e_g1;
      pend_drop = e_g0 && m0_cancel;
      pend_rd   = e_g0 || (e_g1 && m1_wen == 4'd0);
      pend_data = golden[e_g1 ? m1_addr[7:2] : m0_addr[7:2]];
      if (e_g1)
        for (int b = 0; b < 4; b++)
          if (m1_wen[b]) golden[m1_addr[7:2]][8*b +: 8] = m1_wdata[8*b +: 8];
    end
  end

  task automatic step(input logic r0, input logic r1, input logic c, input logic [3:0] wen,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd);
    @(posedge clk);
    #1;
    m0_req = r0; m1_req = r1; m0_cancel = c;
    m1_wen = wen; m0_addr = a0; m1_addr = a1; m1_wdata = wd;
    @(negedge clk);
  endtask

  typedef struct {
    logic r0, r1, c;
    logic aok0, aok1, dok0, dok1;
  } vec_t;

  vec_t vecs [14];

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
      golden[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    end
    //            r0    r1    c     aok0  aok1  dok0  dok1
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with both requesters active: nothing may be granted.
    reset = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_cancel = 1'b0; m1_wen = 4'd0;
    m0_addr = addr_of(1); m1_addr = addr_of(2); m1_wdata = '0;
    @(negedge clk);
    check("rst_aok0", 32'(m0_addr_ok), 0);
    check("rst_aok1", 32'(m1_addr_ok), 0);
    check("rst_en",   32'(ram_en), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rel_aok1", 32'(m1_addr_ok), 1);
    check("rel_aok0", 32'(m0_addr_ok), 0);
    step(0, 0, 0, 4'd0, addr_of(0), addr_of(0), '0);
    check("rel_dok1", 32'(m1_data_ok), 1);

    // Starvation and cancel vectors.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].r0, vecs[i].r1, vecs[i].c, 4'd0, addr_of(i), addr_of(16 + i), '0);
      check($sformatf("vec%0d_aok0", i), 32'(m0_addr_ok), 32'(vecs[i].aok0));
      check($sformatf("vec%0d_aok1", i), 32'(m1_addr_ok), 32'(vecs[i].aok1));
      check($sformatf("vec%0d_dok0", i), 32'(m0_data_ok), 32'(vecs[i].dok0));
      check($sformatf("vec%0d_dok1", i), 32'(m1_data_ok), 32'(vecs[i].dok1));
    end

    // Four back-to-back fetches 0x1c000000..0x1c00000c.
    for (int k = 0; k < 5; k++) begin
      step(k < 4, 0, 0, 4'd0, addr_of(k), addr_of(0), '0);
      check($sformatf("fetch%0d_aok0", k), 32'(m0_addr_ok), 32'(k < 4));
      check($sformatf("fetch%0d_dok0", k), 32'(m0_data_ok), 32'(k > 0));
      if (k > 0) check($sformatf("fetch%0d_rdata", k), m0_rdata, 32'hC0DE_0000 + 32'(k - 1) * 32'h101);
    end

    // M1 write followed immediately by an M0 fetch of the same word.
    step(0, 1, 0, 4'hF, addr_of(0), addr_of(5), 32'hDEAD_BEEF);
    check("wr_aok1", 32'(m1_addr_ok), 1);
    step(1, 0, 0, 4'd0, addr_of(5), addr_of(0), '0);
    check("wr_dok1", 32'(m1_data_ok), 1);
    check("rd_aok0", 32'(m0_addr_ok), 1);
    step(0, 0, 0, 4'd0, addr_of(0), addr_of(0), '0);
    check("rd_dok0", 32'(m0_data_ok), 1);
    check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);

    // Reset between grant and data_ok: the response must never appear.
    step(1, 0, 0, 4'd0, addr_of(9), addr_of(0), '0);
    check("ar_aok0", 32'(m0_addr_ok), 1);
    @(posedge clk);
    #1;
    m0_req = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("ar_dok0_in", 32'(m0_data_ok), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("ar_dok0_out", 32'(m0_data_ok), 0);
    check("ar_dok1_out", 32'(m1_data_ok), 0);

    // Random traffic checked entirely by the reference model.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0,
           addr_of($urandom_range(0, 63)), addr_of($urandom_range(0, 63)), $urandom);
    end
    step(0, 0, 0, 4'd0, addr_of(0), addr_of(0), '0);
    step(0, 0, 0, 4'd0, addr_of(0), addr_of(0), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
